// File: rtl/dram_to_stash_path_unpacker_if.sv
// DRAM-flit input and stash-flit output of the path unpacker, with the per-block sideband.
interface dram_to_stash_path_unpacker_if #(
    parameter int BEDWidth = 512,
    parameter int ORAMU    = 32,
    parameter int ORAML    = 32,
    parameter int MACWidth = 64
) ();
    // Both streams: a flit moves on the rising edge where Valid && Ready; the sender
    // holds Data (and sideband) stable while Valid && !Ready; Ready may depend on Valid.
    logic [BEDWidth-1:0] DRAMData;
    logic                DRAMValid;
    logic                DRAMReady;
    logic [BEDWidth-1:0] StashData;
    logic [ORAMU-1:0]    StashPAddr;
    logic [ORAML-1:0]    StashLeaf;
    logic [MACWidth-1:0] StashMAC;
    logic                StashLast;
    logic                StashValid;
    logic                StashReady;

    modport master (
        output DRAMData, DRAMValid, StashReady,
        input  DRAMReady, StashData, StashPAddr, StashLeaf, StashMAC, StashLast, StashValid
    );

    modport slave (
        input  DRAMData, DRAMValid, StashReady,
        output DRAMReady, StashData, StashPAddr, StashLeaf, StashMAC, StashLast, StashValid
    );
endinterface

// File: rtl/dram_to_stash_path_unpacker.sv
// Unpacks DRAM bucket flits (header, then ORAMZ blocks) into real-block stash flits.
// Header lands in place by flit index; the stash side is a single register slice.
module dram_to_stash_path_unpacker #(
    parameter int          BEDWidth = 512,
    parameter int          ORAMZ    = 4,
    parameter int          ORAMU    = 32,
    parameter int          ORAML    = 32,
    parameter int          ORAMH    = 64,
    parameter int          IVWidth  = 64,
    parameter int          BlkFlits = 8,
    parameter int          PathBkts = 33,
    parameter int          DropInit = 1,
    parameter int unsigned IVInit   = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        PathStart,
    input  logic        PathMode,
    output logic        Busy,
    output logic [15:0] RealBlocks,
    output logic        PathTransition,
    output logic [1:0]  DebugState,
    dram_to_stash_path_unpacker_if.slave Bus
);
    localparam int HdrBits  = ORAMZ * (ORAMH + ORAML + ORAMU + 1) + IVWidth;
    localparam int HdrFlits = (HdrBits + BEDWidth - 1) / BEDWidth;
    localparam int HW       = (HdrFlits > 1) ? $clog2(HdrFlits) : 1;
    localparam int FW       = (BlkFlits > 1) ? $clog2(BlkFlits) : 1;
    localparam int ZW       = (ORAMZ > 1) ? $clog2(ORAMZ) : 1;
    localparam int BW       = $clog2(PathBkts + 1);
    localparam int MW       = (ORAMH > 0) ? ORAMH : 1;
    localparam int VOff     = IVWidth;
    localparam int UOff     = VOff + ORAMZ;
    localparam int LOff     = UOff + ORAMZ * ORAMU;
    localparam int HOff     = LOff + ORAMZ * ORAML;

    typedef enum logic [1:0] {Idle = 2'd0, Hdr = 2'd1, Pld = 2'd2} stateT;

    stateT          state;
    logic           pathMode;
    logic [HW-1:0]  hdrCnt;
    logic [FW-1:0]  flitCnt;
    logic [ZW-1:0]  blkCnt;
    logic [BW-1:0]  bktCnt;
    logic [HdrBits-1:0] hdr;
    logic           dramFire;
    logic           blkReal;
    logic           flitLast;
    logic           blkLast;
    logic           bktLast;
    logic           ivIsInit;
    logic [ORAMZ-1:0] realVec;
    logic [ORAMU-1:0] pAddrArr [ORAMZ];
    logic [ORAML-1:0] leafArr  [ORAMZ];
    logic [MW-1:0]    macArr   [ORAMZ];

    // Each header flit owns a fixed slice; the tail of the last flit is not stored.
    for (genvar k = 0; k < HdrFlits; k++) begin : gHdr
        localparam int Lo = k * BEDWidth;
        localparam int W  = ((HdrBits - Lo) < BEDWidth) ? (HdrBits - Lo) : BEDWidth;
        logic [W-1:0] slice;
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                slice <= '0;
            end else if (state == Hdr && dramFire && hdrCnt == HW'(k)) begin
                slice <= Bus.DRAMData[W-1:0];
            end
        end
        assign hdr[Lo +: W] = slice;
    end

    assign ivIsInit = (hdr[IVWidth-1:0] == IVWidth'(IVInit));

    for (genvar i = 0; i < ORAMZ; i++) begin : gBlk
        assign realVec[i]  = hdr[VOff + i] && !((DropInit != 0) && ivIsInit);
        assign pAddrArr[i] = hdr[UOff + i * ORAMU +: ORAMU];
        assign leafArr[i]  = hdr[LOff + i * ORAML +: ORAML];
        if (ORAMH > 0) begin : gMac
            assign macArr[i] = hdr[HOff + i * ORAMH +: ORAMH];
        end else begin : gNoMac
            assign macArr[i] = '0;
        end
    end

    assign blkReal  = realVec[blkCnt];
    assign flitLast = (flitCnt == FW'(BlkFlits - 1));
    assign blkLast  = (blkCnt == ZW'(ORAMZ - 1));
    assign bktLast  = ((bktCnt + BW'(1)) == (pathMode ? BW'(1) : BW'(PathBkts)));
    assign dramFire = Bus.DRAMValid && Bus.DRAMReady;
    assign DebugState = state;

    // Dummy flits are swallowed regardless of the stash; real ones wait for slice space.
    always_comb begin
        Bus.DRAMReady = 1'b0;
        case (state)
            Hdr:     Bus.DRAMReady = 1'b1;
            Pld:     Bus.DRAMReady = blkReal ? (!Bus.StashValid || Bus.StashReady) : 1'b1;
            default: Bus.DRAMReady = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state          <= Idle;
            pathMode       <= 1'b0;
            hdrCnt         <= '0;
            flitCnt        <= '0;
            blkCnt         <= '0;
            bktCnt         <= '0;
            Busy           <= 1'b0;
            RealBlocks     <= '0;
            PathTransition <= 1'b0;
            Bus.StashValid <= 1'b0;
            Bus.StashData  <= '0;
            Bus.StashPAddr <= '0;
            Bus.StashLeaf  <= '0;
            Bus.StashMAC   <= '0;
            Bus.StashLast  <= 1'b0;
        end else begin
            PathTransition <= 1'b0;
            if (Bus.StashReady) begin
                Bus.StashValid <= 1'b0;
            end
            case (state)
                Idle: begin
                    if (PathStart) begin
                        state      <= Hdr;
                        Busy       <= 1'b1;
                        pathMode   <= PathMode;
                        RealBlocks <= '0;
                        hdrCnt     <= '0;
                        flitCnt    <= '0;
                        blkCnt     <= '0;
                        bktCnt     <= '0;
                    end
                end
                Hdr: begin
                    if (dramFire) begin
                        if (hdrCnt == HW'(HdrFlits - 1)) begin
                            hdrCnt <= '0;
                            state  <= Pld;
                        end else begin
                            hdrCnt <= hdrCnt + HW'(1);
                        end
                    end
                end
                Pld: begin
                    if (dramFire) begin
                        if (blkReal) begin
                            Bus.StashValid <= 1'b1;
                            Bus.StashData  <= Bus.DRAMData;
                            Bus.StashPAddr <= pAddrArr[blkCnt];
                            Bus.StashLeaf  <= leafArr[blkCnt];
                            Bus.StashMAC   <= macArr[blkCnt];
                            Bus.StashLast  <= flitLast;
                            if (flitLast && RealBlocks != 16'hFFFF) begin
                                RealBlocks <= RealBlocks + 16'd1;
                            end
                        end
                        if (flitLast) begin
                            flitCnt <= '0;
                            if (blkLast) begin
                                blkCnt <= '0;
                                bktCnt <= bktCnt + BW'(1);
                                if (bktLast) begin
                                    state          <= Idle;
                                    Busy           <= 1'b0;
                                    PathTransition <= 1'b1;
                                end else begin
                                    state <= Hdr;
                                end
                            end else begin
                                blkCnt <= blkCnt + ZW'(1);
                            end
                        end else begin
                            flitCnt <= flitCnt + FW'(1);
                        end
                    end
                end
                default: state <= Idle;
            endcase
        end
    end
endmodule
